larpix_config_responder: RTL and testbench

//  Chip-side peer of the FPGA master's config traffic. Accepts 63-bit words from the chip UART RX.

---
 rtl/larpix_config_responder.sv | 133 +++++++++++++
 tb/tb_larpix_config_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/larpix_config_responder.sv
// Chip-side config responder: unloads words from the chip UART RX, applies config writes to the
// register map, and answers config reads with an odd-parity reply loaded into the chip UART TX.
module larpix_config_responder #(
    parameter int          WIDTH     = 64,
    parameter int          REGADDR   = 8,
    parameter logic [7:0]  GLOBAL_ID = 8'd255,
    parameter logic [31:0] MAGIC     = 32'h89504E47,
    parameter int          CNTW      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         chip_id,
    input  logic [WIDTH-2:0]   rx_data,
    input  logic               rx_parity_error,
    input  logic               rx_empty,
    output logic               uld_rx_data,
    output logic               regmap_we,
    output logic [REGADDR-1:0] regmap_addr,
    output logic [7:0]         regmap_wdata,
    input  logic [7:0]         regmap_rdata,
    output logic [WIDTH-1:0]   tx_data,
    output logic               ld_tx_data,
    input  logic               tx_busy,
    output logic [CNTW-1:0]    rx_count,
    output logic [CNTW-1:0]    drop_count
);

    typedef enum logic [2:0] {IDLE, CAPTURE, PARSE, WRITE, READ, BUILD, SEND} state_t;

    state_t state, next_state;

    logic [1:0]  pkt_declare;
    logic [7:0]  pkt_chip;
    logic [7:0]  pkt_addr;
    logic [7:0]  pkt_data;
    logic [31:0] pkt_magic;
    logic        pkt_perr;
    logic [7:0]  chip_id_q;

    logic               accept;
    logic               uld_d, we_d, ld_d, drop_inc;
    logic [REGADDR-1:0] addr_d;
    logic [7:0]         wdata_d;
    logic [WIDTH-1:0]   tx_d;
    logic [WIDTH-2:0]   reply_body;

    // Marker and spare bits are carried on the link but play no part in the decode.
    logic unused_rx_bits;
    assign unused_rx_bits = ^rx_data[62:58];

    assign accept = !pkt_perr && pkt_declare[1] && (pkt_magic == MAGIC) &&
                    ((pkt_chip == chip_id_q) || (pkt_chip == GLOBAL_ID));

    // The reply always carries the local ID, even when the request was a broadcast.
    assign reply_body = {1'b1, 4'b0000, MAGIC, regmap_rdata, pkt_addr, chip_id_q, 2'b11};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_empty) next_state = CAPTURE;
            CAPTURE: next_state = PARSE;
            PARSE:   if (!accept)           next_state = IDLE;
                     else if (pkt_declare[0]) next_state = READ;
                     else                   next_state = WRITE;
            WRITE:   next_state = IDLE;
            READ:    next_state = BUILD;
            BUILD:   next_state = SEND;
            SEND:    if (!tx_busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for the registered outputs; addr/wdata are set up one clock ahead of use.
    always_comb begin
        uld_d    = (state == IDLE) && !rx_empty;
        we_d     = (state == WRITE);
        ld_d     = (state == SEND) && !tx_busy;
        drop_inc = (state == PARSE) && !accept;
        addr_d   = regmap_addr;
        wdata_d  = regmap_wdata;
        tx_d     = tx_data;
        if (state == PARSE && accept) begin
            addr_d = pkt_addr;
            if (!pkt_declare[0]) wdata_d = pkt_data;
        end
        if (state == BUILD) tx_d = {~^reply_body, reply_body};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uld_rx_data  <= 1'b0;
            regmap_we    <= 1'b0;
            regmap_addr  <= '0;
            regmap_wdata <= '0;
            tx_data      <= '0;
            ld_tx_data   <= 1'b0;
            rx_count     <= '0;
            drop_count   <= '0;
            pkt_declare  <= '0;
            pkt_chip     <= '0;
            pkt_addr     <= '0;
            pkt_data     <= '0;
            pkt_magic    <= '0;
            pkt_perr     <= 1'b0;
            chip_id_q    <= '0;
        end else begin
            uld_rx_data  <= uld_d;
            regmap_we    <= we_d;
            regmap_addr  <= addr_d;
            regmap_wdata <= wdata_d;
            tx_data      <= tx_d;
            ld_tx_data   <= ld_d;
            if (state == CAPTURE) begin
                pkt_declare <= rx_data[1:0];
                pkt_chip    <= rx_data[9:2];
                pkt_addr    <= rx_data[17:10];
                pkt_data    <= rx_data[25:18];
                pkt_magic   <= rx_data[57:26];
                pkt_perr    <= rx_parity_error;
                chip_id_q   <= chip_id;
                rx_count    <= rx_count + CNTW'(1);
            end
            if (drop_inc && (drop_count != {CNTW{1'b1}}))
                drop_count <= drop_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_larpix_config_responder.sv
// Directed bench for larpix_config_responder: a queued RX model, a registered regmap model and
// strobe monitors; a narrow-counter instance exercises wrap and saturation.
module tb_larpix_config_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  chip_id;
    logic [62:0] rx_data;
    logic        rx_parity_error;
    logic        rx_empty;
    logic        tx_busy;
    logic [7:0]  regmap_rdata;

    logic        uld_rx_data, regmap_we, ld_tx_data;
    logic [7:0]  regmap_addr, regmap_wdata;
    logic [63:0] tx_data;
    logic [15:0] rx_count, drop_count;

    logic        n_uld, n_we, n_ld;
    logic [7:0]  n_addr, n_wdata;
    logic [63:0] n_tx;
    logic [3:0]  n_rx_count, n_drop_count;

    always #5 clk = ~clk;

    larpix_config_responder dut (
        .clk(clk), .reset(reset), .chip_id(chip_id), .rx_data(rx_data),
        .rx_parity_error(rx_parity_error), .rx_empty(rx_empty), .uld_rx_data(uld_rx_data),
        .regmap_we(regmap_we), .regmap_addr(regmap_addr), .regmap_wdata(regmap_wdata),
        .regmap_rdata(regmap_rdata), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
        .tx_busy(tx_busy), .rx_count(rx_count), .drop_count(drop_count)
    );

    larpix_config_responder #(.CNTW(4)) dut_narrow (
        .clk(clk), .reset(reset), .chip_id(chip_id), .rx_data(rx_data),
        .rx_parity_error(rx_parity_error), .rx_empty(rx_empty), .uld_rx_data(n_uld),
        .regmap_we(n_we), .regmap_addr(n_addr), .regmap_wdata(n_wdata),
        .regmap_rdata(regmap_rdata), .tx_data(n_tx), .ld_tx_data(n_ld),
        .tx_busy(tx_busy), .rx_count(n_rx_count), .drop_count(n_drop_count)
    );

    // Register map with one clock of read latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        regmap_rdata <= mem[regmap_addr];
        if (regmap_we) mem[regmap_addr] <= regmap_wdata;
    end

    typedef struct {
        logic [62:0] w;
        logic        p;
    } rx_word_t;
    rx_word_t rxq[$];

    int checks = 0;
    int fails  = 0;
    int we_count = 0;
    int ld_count = 0;
    logic [7:0]  last_addr, last_wdata;
    logic [63:0] last_tx;
    logic        pop_pending = 1'b0;

    localparam logic [31:0] MAGIC = 32'h89504E47;
    // Reply to a read of addr 0x05 holding 0xA7, answered by chip 16 (hand-assembled).
    localparam logic [63:0] REPLY_05_A7 = 64'hC2254139_1E9C1443;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [62:0] mk(input logic [1:0] decl, input logic [7:0] chip,
                                       input logic [7:0] addr, input logic [7:0] data,
                                       input logic [31:0] magic);
        return {1'b1, 4'b0000, magic, data, addr, chip, decl};
    endfunction

    task automatic applyStimulus(input logic [62:0] w, input logic p);
        rx_word_t e;
        e.w = w;
        e.p = p;
        rxq.push_back(e);
    endtask

    // One clock: monitor strobes, then advance the RX model (pops the clock after an unload).
    task automatic cycle();
        @(negedge clk);
        if (regmap_we) begin
            we_count++;
            last_addr  = regmap_addr;
            last_wdata = regmap_wdata;
        end
        if (ld_tx_data) begin
            ld_count++;
            last_tx = tx_data;
        end
        if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
        pop_pending = uld_rx_data;
        if (rxq.size() > 0) begin
            rx_empty        = 1'b0;
            rx_data         = rxq[0].w;
            rx_parity_error = rxq[0].p;
        end else begin
            rx_empty        = 1'b1;
            rx_data         = '0;
            rx_parity_error = 1'b0;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic waitWe(input int limit, output int lat);
        int start;
        start = we_count;
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (we_count != start) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) checkOutput("we_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitLd(input int limit, output int lat);
        int start;
        start = ld_count;
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (ld_count != start) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) checkOutput("ld_timeout", 64'd0, 64'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_uld"},   64'(uld_rx_data),  64'd0);
        checkOutput({tag, "_we"},    64'(regmap_we),    64'd0);
        checkOutput({tag, "_ld"},    64'(ld_tx_data),   64'd0);
        checkOutput({tag, "_addr"},  64'(regmap_addr),  64'd0);
        checkOutput({tag, "_wdata"}, 64'(regmap_wdata), 64'd0);
        checkOutput({tag, "_tx"},    tx_data,           64'd0);
        checkOutput({tag, "_rxcnt"}, 64'(rx_count),     64'd0);
        checkOutput({tag, "_drop"},  64'(drop_count),   64'd0);
    endtask

    initial begin
        int lat, we0, ld0;
        logic [63:0] snap;
        logic stable_bad, uld_bad;

        reset = 1'b1; chip_id = 8'd16; tx_busy = 1'b0;
        rx_data = '0; rx_parity_error = 1'b0; rx_empty = 1'b1;
        cycle();
        cycle();
        checkAllZero("reset");
        reset = 1'b0;
        cycle();

        $display("[TB] write chip 16 addr 05 data A7");
        applyStimulus(mk(2'b10, 8'd16, 8'h05, 8'hA7, MAGIC), 1'b0);
        waitWe(20, lat);
        checkOutput("write_latency", 64'(lat), 64'd4);
        checkOutput("write_addr", 64'(last_addr), 64'h05);
        checkOutput("write_data", 64'(last_wdata), 64'hA7);
        runCycles(4);
        checkOutput("write_we_once", 64'(we_count), 64'd1);
        checkOutput("write_no_ld", 64'(ld_count), 64'd0);

        $display("[TB] read chip 16 addr 05");
        applyStimulus(mk(2'b11, 8'd16, 8'h05, 8'h00, MAGIC), 1'b0);
        waitLd(30, lat);
        checkOutput("read_latency", 64'(lat), 64'd6);
        checkOutput("read_reply", last_tx, REPLY_05_A7);
        checkOutput("read_data_field", 64'(last_tx[25:18]), 64'hA7);
        checkOutput("read_chip_field", 64'(last_tx[9:2]), 64'd16);
        checkOutput("read_parity_odd", 64'(^last_tx), 64'd1);
        runCycles(4);
        checkOutput("read_ld_once", 64'(ld_count), 64'd1);
        checkOutput("read_no_we", 64'(we_count), 64'd1);

        $display("[TB] four dropped words");
        doReset();
        we0 = we_count; ld0 = ld_count;
        applyStimulus(mk(2'b10, 8'd31, 8'h01, 8'h11, MAGIC), 1'b0);
        applyStimulus(mk(2'b10, 8'd16, 8'h02, 8'h22, 32'h89504E46), 1'b0);
        applyStimulus(mk(2'b10, 8'd16, 8'h03, 8'h33, MAGIC), 1'b1);
        applyStimulus(mk(2'b01, 8'd16, 8'h04, 8'h44, MAGIC), 1'b0);
        runCycles(20);
        checkOutput("drop_no_we", 64'(we_count - we0), 64'd0);
        checkOutput("drop_no_ld", 64'(ld_count - ld0), 64'd0);
        checkOutput("drop_count4", 64'(drop_count), 64'd4);
        checkOutput("drop_rx_count4", 64'(rx_count), 64'd4);

        $display("[TB] broadcast read under backpressure with a queued write");
        tx_busy = 1'b1;
        we0 = we_count; ld0 = ld_count;
        applyStimulus(mk(2'b11, 8'd255, 8'h05, 8'h00, MAGIC), 1'b0);
        applyStimulus(mk(2'b10, 8'd16, 8'h22, 8'h3C, MAGIC), 1'b0);
        runCycles(10);
        snap = tx_data;
        stable_bad = 1'b0;
        uld_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tx_data !== snap) stable_bad = 1'b1;
            if (uld_rx_data) uld_bad = 1'b1;
        end
        checkOutput("busy_reply", snap, REPLY_05_A7);
        checkOutput("busy_tx_stable", 64'(stable_bad), 64'd0);
        checkOutput("busy_no_unload", 64'(uld_bad), 64'd0);
        checkOutput("busy_no_ld", 64'(ld_count - ld0), 64'd0);
        checkOutput("busy_rx_count", 64'(rx_count), 64'd5);
        tx_busy = 1'b0;
        waitLd(5, lat);
        checkOutput("busy_loaded", last_tx, REPLY_05_A7);
        waitWe(20, lat);
        checkOutput("queued_addr", 64'(last_addr), 64'h22);
        checkOutput("queued_data", 64'(last_wdata), 64'h3C);
        checkOutput("queued_rx_count", 64'(rx_count), 64'd6);

        $display("[TB] reset during BUILD");
        ld0 = ld_count;
        applyStimulus(mk(2'b11, 8'd16, 8'h05, 8'h00, MAGIC), 1'b0);
        runCycles(5);
        reset = 1'b1;
        cycle();
        checkAllZero("rst_build");
        reset = 1'b0;
        runCycles(12);
        checkOutput("rst_build_no_ld", 64'(ld_count - ld0), 64'd0);

        $display("[TB] reset during SEND");
        tx_busy = 1'b1;
        applyStimulus(mk(2'b11, 8'd16, 8'h05, 8'h00, MAGIC), 1'b0);
        runCycles(7);
        checkOutput("send_pending_tx", tx_data, REPLY_05_A7);
        reset = 1'b1;
        cycle();
        checkAllZero("rst_send");
        reset = 1'b0;
        tx_busy = 1'b0;
        runCycles(12);
        checkOutput("rst_send_no_ld", 64'(ld_count - ld0), 64'd0);
        applyStimulus(mk(2'b10, 8'd16, 8'h40, 8'h5A, MAGIC), 1'b0);
        waitWe(20, lat);
        checkOutput("post_reset_latency", 64'(lat), 64'd4);
        checkOutput("post_reset_addr", 64'(last_addr), 64'h40);
        checkOutput("post_reset_data", 64'(last_wdata), 64'h5A);

        $display("[TB] counter wrap and saturation");
        doReset();
        for (int i = 0; i < 14; i++) applyStimulus(mk(2'b01, 8'd16, 8'(i), 8'h00, MAGIC), 1'b0);
        runCycles(50);
        checkOutput("narrow_drop_E", 64'(n_drop_count), 64'hE);
        checkOutput("narrow_rx_E", 64'(n_rx_count), 64'hE);
        applyStimulus(mk(2'b01, 8'd16, 8'h00, 8'h00, MAGIC), 1'b0);
        runCycles(6);
        checkOutput("narrow_drop_F", 64'(n_drop_count), 64'hF);
        checkOutput("narrow_rx_F", 64'(n_rx_count), 64'hF);
        applyStimulus(mk(2'b00, 8'd16, 8'h00, 8'h00, MAGIC), 1'b0);
        runCycles(6);
        checkOutput("narrow_drop_sat", 64'(n_drop_count), 64'hF);
        checkOutput("narrow_rx_wrap", 64'(n_rx_count), 64'h0);
        checkOutput("wide_drop_16", 64'(drop_count), 64'd16);
        checkOutput("wide_rx_16", 64'(rx_count), 64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
